// File: rtl/port_rd_if.sv
// Egress frontend bus: backend half-word stream in, framed port stream out.
// master = backend/port side driving the stimulus, slave = the frontend.
interface port_rd_if;
  logic        xfer_data_vld;
  logic [15:0] xfer_data;
  logic        end_of_packet;
  logic        xfer_pause;
  logic        ready;
  logic        rd_sop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_eop;
  logic        ovf;
  logic        len_err;

  modport master (
    output xfer_data_vld, xfer_data, end_of_packet, ready,
    input  xfer_pause, rd_sop, rd_vld, rd_data, rd_eop, ovf, len_err
  );

  modport slave (
    input  xfer_data_vld, xfer_data, end_of_packet, ready,
    output xfer_pause, rd_sop, rd_vld, rd_data, rd_eop, ovf, len_err
  );
endinterface

// File: rtl/port_rd_frontend.sv
// Read-side port frontend: buffers backend half-words (plus eop flag) in a
// DEPTH-entry FIFO and replays each packet with sop/vld/eop framing once the
// external port is ready. Optional length check enabled by RD_LEN_CHECK_EN.
module port_rd_frontend #(
  parameter int DEPTH = 64
) (
  input  logic      clk,
  input  logic      rst,
  port_rd_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PAUSE_C = (AW+1)'(DEPTH - 3);

  typedef enum logic [1:0] {IDLE, SOP, DATA, EOP} state_t;

  state_t        state, state_next;
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, drop;
  logic [16:0]   head;

  logic          pause_r, sop_r, vld_r, eop_r, ovf_r;
  logic [15:0]   data_r;

  // No bypass: the head entry is whatever was written on an earlier edge.
  assign head = mem[rd_ptr];
  assign pop  = (state == DATA) && (count != '0);
  assign push = bus.xfer_data_vld && ((count < FULL_C) || pop);
  assign drop = bus.xfer_data_vld && !push;

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Packet sequencer next state; ready only matters before a packet starts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ready && (count != '0)) state_next = SOP;
      SOP:     state_next = DATA;
      DATA:    if (pop && head[16]) state_next = EOP;
      EOP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.end_of_packet, bus.xfer_data};
  end

  // Registered egress framing, overflow flag and early pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_r <= 1'b0;
      sop_r   <= 1'b0;
      vld_r   <= 1'b0;
      eop_r   <= 1'b0;
      ovf_r   <= 1'b0;
      data_r  <= '0;
    end else begin
      pause_r <= (count_next >= PAUSE_C);
      sop_r   <= (state == SOP);
      eop_r   <= (state == EOP);
      vld_r   <= pop;
      ovf_r   <= drop;
      if (pop) data_r <= head[15:0];
    end
  end

  assign bus.xfer_pause = pause_r;
  assign bus.rd_sop     = sop_r;
  assign bus.rd_vld     = vld_r;
  assign bus.rd_data    = data_r;
  assign bus.rd_eop     = eop_r;
  assign bus.ovf        = ovf_r;

`ifdef RD_LEN_CHECK_EN
  logic [9:0] pop_cnt;
  logic [8:0] exp_len, cur_len;
  logic       len_bad, len_err_r;

  // The first popped word carries the length; use it directly on that pop.
  assign cur_len = (pop_cnt == '0) ? head[15:7] : exp_len;

  // Per-packet pop counter; mismatch verdict is taken at the eop pop and
  // reported alongside rd_eop one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt   <= '0;
      exp_len   <= '0;
      len_bad   <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= (state == EOP) && len_bad;
      if (state == SOP) begin
        pop_cnt <= '0;
        len_bad <= 1'b0;
      end else if (pop) begin
        pop_cnt <= pop_cnt + 1'b1;
        if (pop_cnt == '0) exp_len <= head[15:7];
        if (head[16])      len_bad <= ({1'b0, cur_len} != (pop_cnt + 1'b1));
      end
    end
  end

  assign bus.len_err = len_err_r;
`else
  assign bus.len_err = 1'b0;
`endif

endmodule

// File: tb/tb_port_rd_frontend.sv
// Bench for port_rd_frontend: table of packets plus hand-written corner
// sequences; expected half-words go to a scoreboard queue as they are driven
// and are compared when rd_vld appears.
module tb_port_rd_frontend;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  port_rd_if bus();

  port_rd_frontend #(.DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef RD_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  typedef struct {
    int          n;
    logic [15:0] first;
    int          gap_at;
    int          gap_len;
    int          exp_vld;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] sb[$];
  bit          len_q[$];
  int          sop_cnt = 0, vld_cnt = 0, eop_cnt = 0;
  logic        pending_eop = 1'b0;
  logic [15:0] last_data = 16'h0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit len_exp(input logic [15:0] first, input int n);
    return LEN_EN && (int'(first[15:7]) != n);
  endfunction

  task automatic drive_word(input logic [15:0] d, input logic e, input bit accept);
    bus.xfer_data_vld = 1'b1;
    bus.xfer_data     = d;
    bus.end_of_packet = e;
    if (accept) sb.push_back({e, d});
    tick();
    bus.xfer_data_vld = 1'b0;
    bus.end_of_packet = 1'b0;
  endtask

  task automatic send_packet(input int n, input logic [15:0] first, input int gap_at, input int gap_len);
    logic [15:0] d;
    len_q.push_back(len_exp(first, n));
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) tick();
      d = (i == 0) ? first : 16'($urandom_range(0, 65535));
      drive_word(d, (i == n - 1), 1'b1);
    end
  endtask

  task automatic wait_eops(input int target, input int budget);
    int k = 0;
    while (eop_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check("eop_count", eop_cnt, target);
    tick();
  endtask

  // Output monitor: scoreboard compare, eop framing, hold and len_err.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      pending_eop = 1'b0;
      last_data   = 16'h0;
    end else begin
      if (bus.rd_sop) sop_cnt++;
      if (pending_eop)     check("eop_after_last", int'(bus.rd_eop), 1);
      else if (bus.rd_eop) check("spurious_eop", int'(bus.rd_eop), 0);
      if (bus.rd_eop) begin
        eop_cnt++;
        check("len_err_at_eop", int'(bus.len_err), (len_q.size() != 0) ? int'(len_q.pop_front()) : 0);
      end else begin
        check("len_err_idle", int'(bus.len_err), 0);
      end
      pending_eop = 1'b0;
      if (bus.rd_vld) begin
        vld_cnt++;
        if (sb.size() == 0) begin
          check("sb_underrun", int'(bus.rd_vld), 0);
        end else begin
          e = sb.pop_front();
          check("rd_data", int'(bus.rd_data), int'(e[15:0]));
          pending_eop = e[16];
        end
        last_data = bus.rd_data;
      end else begin
        check("rd_data_hold", int'(bus.rd_data), int'(last_data));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int s0, v0, e0, cnt, lag;

    tbl[0] = '{n: 4,  first: 16'h0205, gap_at: -1, gap_len: 0, exp_vld: 4};
    tbl[1] = '{n: 1,  first: 16'h0080, gap_at: -1, gap_len: 0, exp_vld: 1};
    tbl[2] = '{n: 4,  first: 16'h0205, gap_at: 2,  gap_len: 5, exp_vld: 4};
    tbl[3] = '{n: 5,  first: 16'h0205, gap_at: -1, gap_len: 0, exp_vld: 5};
    tbl[4] = '{n: 64, first: 16'h2000, gap_at: -1, gap_len: 0, exp_vld: 64};
    tbl[5] = '{n: 50, first: 16'h1900, gap_at: -1, gap_len: 0, exp_vld: 50};
    tbl[6] = '{n: 36, first: 16'h1200, gap_at: -1, gap_len: 0, exp_vld: 36};

    rst = 1'b1;
    bus.xfer_data_vld = 1'b0;
    bus.xfer_data     = 16'h0;
    bus.end_of_packet = 1'b0;
    bus.ready         = 1'b0;
    repeat (3) tick();
    check("rst_pause", int'(bus.xfer_pause), 0);
    check("rst_sop",   int'(bus.rd_sop), 0);
    check("rst_vld",   int'(bus.rd_vld), 0);
    check("rst_eop",   int'(bus.rd_eop), 0);
    check("rst_ovf",   int'(bus.ovf), 0);
    check("rst_len",   int'(bus.len_err), 0);
    check("rst_data",  int'(bus.rd_data), 0);
    rst = 1'b0;
    tick();

    // Latency: two single-word packets pushed on consecutive edges.
    bus.ready = 1'b1;
    e0 = eop_cnt;
    len_q.push_back(len_exp(16'h0080, 1));
    drive_word(16'h0080, 1'b1, 1'b1);            // edge t
    check("lat_sop_t", int'(bus.rd_sop), 0);
    len_q.push_back(len_exp(16'h0081, 1));
    drive_word(16'h0081, 1'b1, 1'b1);            // edge t+1
    check("lat_sop_t1", int'(bus.rd_sop), 0);
    tick();                                       // t+2
    check("lat_sop_t2", int'(bus.rd_sop), 1);
    check("lat_vld_t2", int'(bus.rd_vld), 0);
    tick();                                       // t+3
    check("lat_vld_t3", int'(bus.rd_vld), 1);
    check("lat_data_t3", int'(bus.rd_data), 16'h0080);
    tick();                                       // t+4
    check("lat_eop_t4", int'(bus.rd_eop), 1);
    tick();                                       // t+5
    check("lat_sop2_t5", int'(bus.rd_sop), 0);
    tick();                                       // t+6
    check("lat_sop2_t6", int'(bus.rd_sop), 1);
    wait_eops(e0 + 2, 50);

    // Table-driven packets: single, minimum, gap, length, wrap-around.
    for (int i = 0; i < 7; i++) begin
      s0 = sop_cnt; v0 = vld_cnt; e0 = eop_cnt;
      send_packet(tbl[i].n, tbl[i].first, tbl[i].gap_at, tbl[i].gap_len);
      wait_eops(e0 + 1, 300);
      check($sformatf("vec%0d_vld", i), vld_cnt - v0, tbl[i].exp_vld);
      check($sformatf("vec%0d_sop", i), sop_cnt - s0, 1);
      check($sformatf("vec%0d_eop", i), eop_cnt - e0, 1);
    end

    // Ready gating, then ready dropped mid-packet.
    bus.ready = 1'b0;
    s0 = sop_cnt; e0 = eop_cnt;
    send_packet(4, 16'h0205, -1, 0);
    repeat (10) tick();
    check("gate_no_sop", sop_cnt - s0, 0);
    bus.ready = 1'b1;
    tick();
    check("gate_sop_r", int'(bus.rd_sop), 0);
    tick();
    check("gate_sop_r1", int'(bus.rd_sop), 1);
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gate_stream_vld", int'(bus.rd_vld), 1);
    end
    tick();
    check("gate_eop", int'(bus.rd_eop), 1);
    wait_eops(e0 + 1, 20);

    // Fill with 2-cycle-lag pause honouring, then overflow, then full push+pop.
    bus.ready = 1'b0;
    cnt = 0; lag = 0;
    v0 = vld_cnt; e0 = eop_cnt;
    len_q.push_back(1'b0);
    for (int k = 0; k < 80 && lag < 3; k++) begin
      drive_word(16'($urandom_range(0, 65535)), 1'b0, 1'b1);
      cnt++;
      check("fill_pause", int'(bus.xfer_pause), int'(cnt >= 61));
      check("fill_no_ovf", int'(bus.ovf), 0);
      if (bus.xfer_pause) lag++;
    end
    check("fill_count", cnt, 63);
    drive_word(16'hBEEF, 1'b1, 1'b1);            // 64th word, last of packet
    check("full64_no_ovf", int'(bus.ovf), 0);
    check("full64_pause", int'(bus.xfer_pause), 1);
    drive_word(16'hDEAD, 1'b0, 1'b0);            // dropped
    check("ovf_pulse", int'(bus.ovf), 1);
    tick();
    check("ovf_one_cycle", int'(bus.ovf), 0);
    // The 64-word packet's length field is arbitrary; recompute its verdict.
    void'(len_q.pop_back());
    len_q.push_back(len_exp(sb[0][15:0], 64));
    bus.ready = 1'b1;
    tick();                                       // SOP
    tick();                                       // DATA, rd_sop visible
    check("full_sop", int'(bus.rd_sop), 1);
    len_q.push_back(len_exp(16'h0080, 1));
    drive_word(16'h0080, 1'b1, 1'b1);            // push at full with pop
    check("full_pushpop_no_ovf", int'(bus.ovf), 0);
    wait_eops(e0 + 2, 300);
    check("full_vld_total", vld_cnt - v0, 65);
    check("drain_pause", int'(bus.xfer_pause), 0);

    // Reset mid-packet, then a clean packet.
    bus.ready = 1'b1;
    len_q.push_back(1'b0);
    for (int i = 0; i < 10; i++)
      drive_word(16'($urandom_range(0, 65535)), (i == 9), 1'b1);
    rst = 1'b1;
    sb.delete();
    len_q.delete();
    tick();
    check("mid_rst_sop",  int'(bus.rd_sop), 0);
    check("mid_rst_vld",  int'(bus.rd_vld), 0);
    check("mid_rst_eop",  int'(bus.rd_eop), 0);
    check("mid_rst_data", int'(bus.rd_data), 0);
    check("mid_rst_pause", int'(bus.xfer_pause), 0);
    rst = 1'b0;
    e0 = eop_cnt;
    repeat (4) begin
      tick();
      check("abort_no_eop", int'(bus.rd_eop), 0);
    end
    v0 = vld_cnt;
    send_packet(3, 16'h0180, -1, 0);
    wait_eops(e0 + 1, 50);
    check("post_rst_vld", vld_cnt - v0, 3);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/port_rd_frontend.md
# port_rd_frontend

Read-side port frontend: the egress counterpart of the write frontend. It accepts a half-word stream from the SRAM read backend into a 64-entry FIFO, then replays each packet to the external port using the `rd_sop` / `rd_vld` / `rd_eop` framing. It throttles the backend with a two-cycle-early pause and gates packet starts on the external `ready`.

## Interface
- `DEPTH`, default 64: FIFO depth in half-words; must be a power of two and ≥8.
- `clk`, input, 1: sole clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `xfer_data_vld`, input, 1: backend half-word valid this cycle.
- `xfer_data`, input, 16: backend half-word.
- `end_of_packet`, input, 1: qualified by `xfer_data_vld`; marks the last half-word of a packet.
- `xfer_pause`, output, 1: request to the backend to stop sending.
- `ready`, input, 1: the external port can accept a new packet.
- `rd_sop`, output, 1: one-cycle start-of-packet pulse.
- `rd_vld`, output, 1: `rd_data` is valid.
- `rd_data`, output, 16: egress half-word.
- `rd_eop`, output, 1: one-cycle end-of-packet pulse.
- `ovf`, output, 1: one-cycle pulse; a backend half-word was dropped because the FIFO was full.
- `len_err`, output, 1: present only with `RD_LEN_CHECK_EN`; see Configuration.

## Operation
- **FIFO**
  - Entries are 17 bits: the data half-word plus an eop flag.
  - `wr_ptr` and `rd_ptr` are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is `log2(DEPTH)+1` bits.
- **Push**: on `xfer_data_vld`, if `count < DEPTH` or a pop occurs in the same cycle, write `{end_of_packet, xfer_data}` at `wr_ptr`. Otherwise drop the word and pulse `ovf`.
- **Pop**: allowed only in state DATA with `count != 0`.
  - There is no bypass: a half-word pushed at edge t is poppable no earlier than edge t+1.
  - A simultaneous push and pop leaves `count` unchanged.
- **FSM states**: IDLE, SOP, DATA, EOP.
  - IDLE → SOP when `ready` is high and `count != 0`. `ready` is sampled only in IDLE.
  - SOP → DATA unconditionally.
  - DATA: pop when `count != 0`. If the popped entry has its eop flag set, go to EOP. If `count == 0`, stay in DATA with `rd_vld` low; these gaps are legal.
  - EOP → IDLE unconditionally.
  - Once a packet starts it always runs to completion; `ready` dropping mid-packet is ignored.
- **Output registers**
  - `rd_sop` is high exactly during the SOP cycle.
  - `rd_vld` and `rd_data` are registered from the popped entry.
  - `rd_eop` is high exactly during the EOP cycle.
  - `rd_data` holds its last value when `rd_vld` is low.
- **Pause**: `xfer_pause` is a registered copy of (`count_next ≥ DEPTH-3`). Up to 2 half-words arriving after `xfer_pause` rises must be absorbed without overflow.

## Timing
- **Reset values**
  - `xfer_pause`, `rd_sop`, `rd_vld`, `rd_eop`, `ovf`, `len_err` = 0.
  - `rd_data` = 16'h0.
  - Pointers and `count` = 0; FSM = IDLE.
  - Asserting `rst` mid-packet discards all FIFO contents and the in-flight packet. No `rd_eop` is emitted for the aborted packet.
- **Latencies**
  - Word pushed at edge t into an empty FIFO with the FSM in IDLE and `ready` high: `rd_sop` at t+2, first `rd_vld` at t+3.
  - Last `rd_vld` at cycle u: `rd_eop` at u+1, IDLE at u+2, earliest next `rd_sop` at u+3.
- **Minimum packet**: 1 half-word, giving SOP, one `rd_vld`, EOP.
- **Full FIFO with push and pop in the same cycle**: the push is accepted and `ovf` stays low.
- **Wrap-around**: pointers roll over from `DEPTH-1` to 0 with no bubble.

## Configuration
- `RD_LEN_CHECK_EN` defined:
  - Latch bits [15:7] of the first popped half-word of each packet as the expected length, in half-words.
  - Count popped half-words with a 10-bit counter.
  - At the eop pop, pulse `len_err` in the same cycle as `rd_eop` if the count differs from the latched length.
- `RD_LEN_CHECK_EN` undefined: `len_err` is tied to 0 and the length logic is absent. Packet boundaries come only from `end_of_packet`.

## Test plan
- **Single packet**: 4 half-words pushed back-to-back, first = 16'h0205 (length 4), `ready` high → `rd_sop` once, 4 `rd_vld` with identical data in order, `rd_eop` one cycle after the last, `len_err` 0.
- **Ready gating**: packet buffered while `ready` is low for 10 cycles → no `rd_sop` until 2 cycles after `ready` rises. Drop `ready` mid-packet → streaming continues uninterrupted.
- **Underflow gap**: backend sends 2 half-words, idles 5 cycles, then sends 2 more with eop → `rd_vld` low during the gap, 4 `rd_vld` total, single `rd_eop`.
- **Full/pause**: `ready` low, backend pushes continuously while honouring `xfer_pause` with 2-cycle lag → `xfer_pause` high once `count` reaches 61, no `ovf`. Ignore `xfer_pause` → `ovf` pulses on the first push at `count` = 64.
- **Wrap and reset**: stream 3 packets totalling 150 half-words → all data intact across pointer wrap. Assert `rst` mid-packet → all outputs 0 the next cycle, and a following packet is emitted cleanly.
- **`RD_LEN_CHECK_EN`**: header declares length 4, packet carries 5 half-words → `len_err` pulse coincident with `rd_eop`.
